// File: rtl/ifetch.sv
// ifetch: instruction-fetch initiator for the rv32i core.
// Owns the PC, drives imem_addr (combinational memory answers in the same
// cycle), buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to
// decode over a valid/ready handshake. A redirect flushes the FIFO.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect loads the PC and parks the FSM in FAULT
//   undefined : redirect_pc[1:0] is forced to 2'b00 and fault is tied low
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_nxt;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_fifo_pc    [DEPTH];
    logic [31:0]     r_fifo_instr [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_redir;
    logic            w_pop;
    logic            w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    // A redirect is honoured in every state except FAULT.
    assign w_redir = redirect_valid && (r_state != S_FAULT);

    assign out_valid = !w_empty && (r_state != S_FAULT);
    assign out_instr = r_fifo_instr[r_rptr];
    assign out_pc    = r_fifo_pc[r_rptr];
    assign imem_addr = r_pc;

    assign w_pop  = out_valid && out_ready;
    // A full FIFO can still accept a push when the head leaves this cycle.
    assign w_push = (r_state == S_RUN) && fetch_en && !redirect_valid && (!w_full || w_pop);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign fault = (r_state == S_FAULT);
`else
    logic w_unused_lsbs;
    assign fault         = 1'b0;
    assign w_unused_lsbs = ^redirect_pc[1:0];
`endif

    // Next-state and next-PC selection: redirect beats push, push advances PC.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE:  begin
                if (fetch_en) w_state_nxt = S_RUN;
                else          w_state_nxt = S_IDLE;
            end
            S_RUN:   begin
                if (!fetch_en) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_RUN;
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_redir) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
            w_pc_nxt = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) w_state_nxt = S_FAULT;
            else                           w_state_nxt = w_state_nxt;
`else
            w_pc_nxt = {redirect_pc[31:2], 2'b00};
`endif
        end else if (w_push) begin
            w_pc_nxt = r_pc + 32'd4;
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // State, PC and FIFO bookkeeping; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_redir) begin
                r_wptr  <= {AW{1'b0}};
                r_rptr  <= {AW{1'b0}};
                r_count <= {CW{1'b0}};
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                else        r_wptr <= r_wptr;
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                else        r_rptr <= r_rptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage: captures {pc, imem_data} only in push cycles.
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_fifo_pc[r_wptr]    <= r_pc;
            r_fifo_instr[r_wptr] <= imem_data;
        end else begin
            r_fifo_pc[r_wptr]    <= r_fifo_pc[r_wptr];
            r_fifo_instr[r_wptr] <= r_fifo_instr[r_wptr];
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: scoreboard queue of expected PCs per scenario.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    // Instruction memory model: mem[1] holds addi x1,x0,42; other words are address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'd1) return 32'h02A00093;
        else                  return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_data = mem_word(imem_addr);

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_stream;
        int waited;
        exp_q.delete();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        fetch_en = 1'b1; out_ready = 1'b1;
        waited = 0;
        while (!out_valid && waited < 8) begin tick; waited++; end
        n_cmp++; if (waited !== 2) begin n_err++; $display("FAIL stream_latency: got %0d cycles want 2", waited); end
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_pc !== e) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, out_pc, e); end
            n_cmp++; if (out_instr !== mem_word(e)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, out_instr, mem_word(e)); end
            if (e == 32'h4) begin
                n_cmp++; if (out_instr !== 32'h02A00093) begin n_err++; $display("FAIL stream_addi: got %h want 02a00093", out_instr); end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        apply_reset;
        fetch_en = 1'b1; out_ready = 1'b0;
        repeat (6) tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL bp_head: got %h want 00000000", out_pc); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_addr_hold: got %h want 00000008", imem_addr); end
        exp_q.delete();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_pc !== e) begin n_err++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, out_pc, e); end
            tick;
        end
    endtask

    task automatic test_redirect_flush;
        out_ready = 1'b0;
        repeat (3) tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL flush_addr: got %h want 00000040", imem_addr); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_target_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL flush_target_pc: got %h want 00000040", out_pc); end
        n_cmp++; if (out_instr !== mem_word(32'h40)) begin n_err++; $display("FAIL flush_target_instr: got %h want %h", out_instr, mem_word(32'h40)); end
    endtask

    task automatic test_wrap;
        int waited;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick;
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
        waited = 0;
        while (!out_valid && waited < 6) begin tick; waited++; end
        n_cmp++; if (waited !== 1) begin n_err++; $display("FAIL wrap_latency: got %0d cycles want 1", waited); end
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_pc !== e) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, out_pc, e); end
            n_cmp++; if (out_instr !== mem_word(e)) begin n_err++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, out_instr, mem_word(e)); end
            tick;
        end
    endtask

    task automatic test_reset_priority;
        out_ready = 1'b0;
        repeat (3) tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstp_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstp_valid: got %b want 0", out_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rstp_addr: got %h want 00000000", imem_addr); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rstp_fault: got %b want 0", fault); end
        rst_n = 1'b1; redirect_valid = 1'b0;
    endtask

    task automatic test_misalign;
        fetch_en = 1'b1; out_ready = 1'b1;
        tick; tick;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
        tick;
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", fault); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault_hold[%0d]: got %b want 1", k, fault); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_valid_hold[%0d]: got %b want 0", k, out_valid); end
            n_cmp++; if (imem_addr !== 32'h6) begin n_err++; $display("FAIL mis_addr_hold[%0d]: got %h want 00000006", k, imem_addr); end
            tick;
        end
        apply_reset;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_fault_clear: got %b want 0", fault); end
`else
        n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL mis_addr: got %h want 00000004", imem_addr); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_fault: got %b want 0", fault); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_flush: got %b want 0", out_valid); end
        tick;
        n_cmp++; if (out_pc !== 32'h4 || out_valid !== 1'b1) begin n_err++; $display("FAIL mis_target: got pc %h valid %b want 00000004 1", out_pc, out_valid); end
        n_cmp++; if (out_instr !== 32'h02A00093) begin n_err++; $display("FAIL mis_instr: got %h want 02a00093", out_instr); end
`endif
    endtask

    task automatic test_pause;
        apply_reset;
        fetch_en = 1'b1; out_ready = 1'b0;
        tick; tick;
        fetch_en = 1'b0;
        repeat (3) tick;
        n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL pause_addr: got %h want 00000004", imem_addr); end
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL pause_head: got valid %b pc %h want 1 00000000", out_valid, out_pc); end
        out_ready = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pause_drain: got %b want 0", out_valid); end
        tick;
        n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin n_err++; $display("FAIL pause_empty_pop: got valid %b addr %h want 0 00000004", out_valid, imem_addr); end
        fetch_en = 1'b1;
        tick; tick;
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_err++; $display("FAIL pause_resume: got valid %b pc %h want 1 00000004", out_valid, out_pc); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL pause_resume_addr: got %h want 00000008", imem_addr); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_flush;
        test_wrap;
        test_reset_priority;
        test_misalign;
        test_pause;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
